// File: rtl/clock_divider_pkg.sv
// Shared types and constants for the programmable clock divider.
package clock_divider_pkg;

  typedef enum logic {
    CH_OFF = 1'b0,
    CH_RUN = 1'b1
  } ch_state_e;

  // Smallest divisor a channel will hold; smaller writes are raised to this.
  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clock_divider_prog_ch.sv
// One divider channel: run/stop FSM, period counter, pending divisor, registered outputs.
//
//  state  | meaning
//  -------+-----------------------------------------------------------------
//  CH_OFF | idle, counter held at 0, outputs low; pending divisor applied next cycle
//  CH_RUN | counting 0..D-1; stop and divisor changes take effect at cnt==D-1
module clock_divider_prog_ch
  import clock_divider_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_wr,
  input  logic [DIV_WIDTH-1:0] i_wr_div,
  output logic                 o_pending,
  output logic                 o_divided_clk,
  output logic                 o_tick,
  output logic                 o_running
);

  ch_state_e            state_q, state_nxt;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_nxt;
  logic [DIV_WIDTH-1:0] div_q, div_nxt;
  logic [DIV_WIDTH-1:0] pend_div_q;
  logic                 pend_q;
  logic                 apply;
  logic                 boundary;
  logic [DIV_WIDTH-1:0] half_nxt;
  logic [DIV_WIDTH-1:0] wr_div_s;
  logic                 dclk_nxt;
  logic                 tick_nxt;

  assign boundary  = (cnt_q == div_q - DIV_WIDTH'(1));
  assign wr_div_s  = (i_wr_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : i_wr_div;
  assign o_pending = pend_q;

  // Next state, counter and divisor; outputs are derived from the next values so they stay registered.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = '0;
    div_nxt   = div_q;
    apply     = 1'b0;
    case (state_q)
      CH_OFF: begin
        if (pend_q) begin
          div_nxt = pend_div_q;
          apply   = 1'b1;
        end
        if (i_en) state_nxt = CH_RUN;
      end
      CH_RUN: begin
        if (boundary) begin
          if (pend_q) begin
            div_nxt = pend_div_q;
            apply   = 1'b1;
          end
          if (!i_en) state_nxt = CH_OFF;
        end else begin
          cnt_nxt = cnt_q + DIV_WIDTH'(1);
        end
      end
      default: state_nxt = CH_OFF;
    endcase
    // ceil(D/2) without widening: D=2^W-1 stays in range.
    half_nxt = (div_nxt >> 1) + {{(DIV_WIDTH-1){1'b0}}, div_nxt[0]};
    dclk_nxt = (state_nxt == CH_RUN) && (cnt_nxt < half_nxt);
    tick_nxt = (state_nxt == CH_RUN) && (cnt_nxt == div_nxt - DIV_WIDTH'(1));
  end

  // Channel state, divisor bookkeeping and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= CH_OFF;
      cnt_q         <= '0;
      div_q         <= DIV_WIDTH'(DEFAULT_DIV);
      pend_div_q    <= '0;
      pend_q        <= 1'b0;
      o_divided_clk <= 1'b0;
      o_tick        <= 1'b0;
      o_running     <= 1'b0;
    end else begin
      state_q       <= state_nxt;
      cnt_q         <= cnt_nxt;
      div_q         <= div_nxt;
      o_divided_clk <= dclk_nxt;
      o_tick        <= tick_nxt;
      o_running     <= (state_nxt == CH_RUN);
      // A write is only accepted while nothing is pending, so it never collides with apply.
      if (i_wr) begin
        pend_q     <= 1'b1;
        pend_div_q <= wr_div_s;
      end else if (apply) begin
        pend_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_divider_prog.sv
// N-channel runtime-programmable clock divider: write decode, ready mux and channel array.
// Outputs are clock-like levels; use o_tick as an enable or buffer o_divided_clk properly.
module clock_divider_prog
  import clock_divider_pkg::*;
#(
  parameter  int N           = 4,
  parameter  int DIV_WIDTH   = 8,
  parameter  int DEFAULT_DIV = 2,
  localparam int CH_W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [N-1:0]         i_en,
  input  logic                 i_cfg_valid,
  input  logic [CH_W-1:0]      i_cfg_ch,
  input  logic [DIV_WIDTH-1:0] i_cfg_div,
  output logic                 o_cfg_ready,
  output logic [N-1:0]         o_divided_clk,
  output logic [N-1:0]         o_tick,
  output logic [N-1:0]         o_running
);

  logic [N-1:0] pending;
  logic [N-1:0] wr;

  // Ready follows the addressed channel's pending flag; unmapped channels always accept and drop.
  always_comb begin
    o_cfg_ready = 1'b1;
    wr          = '0;
    for (int i = 0; i < N; i++) begin
      if (i_cfg_ch == CH_W'(i)) begin
        o_cfg_ready = !pending[i];
        wr[i]       = i_cfg_valid && !pending[i];
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_ch
    clock_divider_prog_ch #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_en          (i_en[g]),
      .i_wr          (wr[g]),
      .i_wr_div      (i_cfg_div),
      .o_pending     (pending[g]),
      .o_divided_clk (o_divided_clk[g]),
      .o_tick        (o_tick[g]),
      .o_running     (o_running[g])
    );
  end

endmodule
